// File: rtl/spi_pkg.sv
// +--------------------------------------------------------------------+
// | spi_pkg : shared types and helpers for the spi_master_param slice  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_param_if.sv
// +--------------------------------------------------------------------+
// | spi_master_param_if : CPU-side controls plus SPI pins              |
// | Optional loopback control under SPI_LOOPBACK_EN.  Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1
);
  import spi_pkg::*;

  localparam int CS_W = cs_width(NUM_CS);

  logic [DATA_W-1:0] tx_data;
  logic              start;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic              cs_hold;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

`ifdef SPI_LOOPBACK_EN
  logic              loopback;

  modport master (
    input  tx_data, start, cs_sel, cpol, cpha, cs_hold, loopback, miso,
    output rx_data, rx_valid, busy, sclk, mosi, cs_n
  );

  modport slave (
    output tx_data, start, cs_sel, cpol, cpha, cs_hold, loopback, miso,
    input  rx_data, rx_valid, busy, sclk, mosi, cs_n
  );
`else
  modport master (
    input  tx_data, start, cs_sel, cpol, cpha, cs_hold, miso,
    output rx_data, rx_valid, busy, sclk, mosi, cs_n
  );

  modport slave (
    output tx_data, start, cs_sel, cpol, cpha, cs_hold, miso,
    input  rx_data, rx_valid, busy, sclk, mosi, cs_n
  );
`endif

endinterface

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// +--------------------------------------------------------------------+
// | spi_clk_gen : SCLK divider emitting leading/trailing edge ticks    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cpol,
  output logic lead_tick,
  output logic trail_tick,
  output logic sclk
);

  localparam int              DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic             r_sclk;
  logic             w_tick;

  assign w_tick     = en && (r_div == DIV_LAST);
  assign lead_tick  = w_tick && !r_phase;
  assign trail_tick = w_tick &&  r_phase;
  assign sclk       = r_sclk;

  // Outside XFER the clock parks at the idle level; the caller presents
  // the new cpol on the accept cycle so SETUP already shows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_phase <= 1'b0;
      r_sclk  <= 1'b0;
    end else if (!en) begin
      r_div   <= '0;
      r_phase <= 1'b0;
      r_sclk  <= cpol;
    end else if (w_tick) begin
      r_div   <= '0;
      r_phase <= ~r_phase;
      r_sclk  <= ~r_sclk;
    end else begin
      r_div   <= r_div + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_param.sv
// +--------------------------------------------------------------------+
// | spi_master_param : parametrised SPI master, all CPOL/CPHA modes    |
// | Define SPI_LOOPBACK_EN for internal mosi->rx loopback.  Rev 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_param_if.master bus
);

  localparam int               CS_W      = cs_width(NUM_CS);
  localparam int               DIV_W     = $clog2(CLK_DIV + 1);
  localparam int               EDGE_W    = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  state_t              r_state;
  spi_mode_t           r_mode;
  logic                r_hold;
  logic [DIV_W-1:0]    r_cnt;
  logic [EDGE_W-1:0]   r_edge;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_busy;
  logic                r_mosi;
  logic [NUM_CS-1:0]   r_cs_n;

  logic                w_accept;
  logic                w_cpol;
  logic                w_lead;
  logic                w_trail;
  logic                w_tick;
  logic                w_sample;
  logic                w_shift;
  logic                w_rx_bit;
  logic                w_sclk;
  logic [NUM_CS-1:0]   w_cs_dec;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_cpol   = w_accept ? bus.cpol : r_mode.cpol;
  assign w_tick   = w_lead | w_trail;
  assign w_sample = r_mode.cpha ? w_trail : w_lead;
  // First leading edge (cpha=1) re-presents the MSB; last trailing edge (cpha=0) has no next bit.
  assign w_shift  = r_mode.cpha ? (w_lead  && (r_edge != '0))
                                : (w_trail && (r_edge != EDGE_LAST));

`ifdef SPI_LOOPBACK_EN
  logic r_loopback;
  assign w_rx_bit = r_loopback ? r_mosi : bus.miso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loopback <= 1'b0;
    end else if (w_accept) begin
      r_loopback <= bus.loopback;
    end
  end
`else
  assign w_rx_bit = bus.miso;
`endif

  // An out-of-range select matches no line, so every cs_n stays high.
  for (genvar g = 0; g < NUM_CS; g++) begin : g_cs_dec
    assign w_cs_dec[g] = (bus.cs_sel != CS_W'(g));
  end

  spi_clk_gen #(
    .CLK_DIV    (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (r_state == XFER),
    .cpol       (w_cpol),
    .lead_tick  (w_lead),
    .trail_tick (w_trail),
    .sclk       (w_sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mode     <= '0;
      r_hold     <= 1'b0;
      r_cnt      <= '0;
      r_edge     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mode.cpol <= bus.cpol;
            r_mode.cpha <= bus.cpha;
            r_hold      <= bus.cs_hold;
            r_tx        <= bus.tx_data;
            r_mosi      <= bus.tx_data[DATA_W-1];
            r_cs_n      <= w_cs_dec;
            r_busy      <= 1'b1;
            r_cnt       <= DIV_LAST;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_edge  <= '0;
            r_state <= XFER;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        XFER: begin
          if (w_sample) begin
            r_rx <= {r_rx[DATA_W-2:0], w_rx_bit};
          end
          if (w_shift) begin
            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            r_mosi <= r_tx[DATA_W-2];
          end
          if (w_tick) begin
            if (r_edge == EDGE_LAST) begin
              r_cnt   <= DIV_LAST;
              r_state <= HOLD;
            end else begin
              r_edge <= r_edge + 1'b1;
            end
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_rx_data  <= r_rx;
            r_rx_valid <= 1'b1;
            r_busy     <= 1'b0;
            if (!r_hold) begin
              r_cs_n <= '1;
            end
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = r_busy;
  assign bus.sclk     = w_sclk;
  assign bus.mosi     = r_mosi;
  assign bus.cs_n     = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_param.sv
// +--------------------------------------------------------------------+
// | tb_spi_master_param : randomized bench with edge-aware SPI slave   |
// | Loopback cases compiled only with SPI_LOOPBACK_EN.  Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spi_master_param;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 2;
  localparam int NUM_CS  = 4;
  localparam int LAT     = (2 * DATA_W + 2) * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS)) tb_if ();

  spi_master_param #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .NUM_CS  (NUM_CS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tb_if.master)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural slave: reacts to SCLK transitions classified against its own cpol/cpha.
  logic       slv_active = 1'b0;
  logic       slv_cpol, slv_cpha;
  logic [7:0] slv_word, slv_cap;
  int         slv_lead, slv_trail, slv_edges;

  always @(tb_if.sclk) begin
    if (slv_active) begin
      slv_edges++;
      if (tb_if.sclk !== slv_cpol) begin
        if (!slv_cpha) slv_cap = {slv_cap[6:0], tb_if.mosi};
        else begin
          if (slv_lead < 8) tb_if.miso = slv_word[7 - slv_lead];
          slv_lead++;
        end
      end else begin
        if (!slv_cpha) begin
          slv_trail++;
          if (slv_trail < 8) tb_if.miso = slv_word[7 - slv_trail];
        end else slv_cap = {slv_cap[6:0], tb_if.mosi};
      end
    end
  end

  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] srx, input logic cpol,
                         input logic cpha, input logic [1:0] sel, input logic hold,
                         input logic poke, input logic lb);
    logic [3:0] cs_exp;
    logic [3:0] cs_after;
    logic [7:0] rx_exp;
    int         lat;
    int         extra;
    cs_exp   = ~(4'b0001 << sel);
    cs_after = hold ? cs_exp : 4'hF;
    rx_exp   = lb ? tx : srx;
    @(negedge clk);
    tb_if.tx_data = tx;
    tb_if.cpol    = cpol;
    tb_if.cpha    = cpha;
    tb_if.cs_sel  = sel;
    tb_if.cs_hold = hold;
`ifdef SPI_LOOPBACK_EN
    tb_if.loopback = lb;
`endif
    slv_word  = srx;
    slv_cpol  = cpol;
    slv_cpha  = cpha;
    slv_cap   = 8'h00;
    slv_lead  = 0;
    slv_trail = 0;
    slv_edges = 0;
    tb_if.miso  = cpha ? 1'b0 : srx[7];
    tb_if.start = 1'b1;
    @(posedge clk); #1;
    tb_if.start = 1'b0;
    slv_active  = 1'b1;
    check_value("busy_up", tb_if.busy, 1);
    check_value("cs_start", tb_if.cs_n, cs_exp);
    lat = -1;
    for (int c = 1; c <= 3 * LAT; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        tb_if.tx_data = ~tx;
        tb_if.cpol    = ~cpol;
        tb_if.cpha    = ~cpha;
      end
      if (poke && c == 10) begin
        tb_if.tx_data = 8'($urandom());
        tb_if.start   = 1'b1;
      end
      if (poke && c == 11) tb_if.start = 1'b0;
      if (c == 20) check_value("cs_mid", tb_if.cs_n, cs_exp);
      if (tb_if.rx_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    slv_active = 1'b0;
    check_value("latency", lat, LAT);
    check_value("rx_data", tb_if.rx_data, rx_exp);
    check_value("mosi_word", slv_cap, tx);
    check_value("sclk_edges", slv_edges, 2 * DATA_W);
    check_value("sclk_idle", tb_if.sclk, cpol);
    check_value("busy_down", tb_if.busy, 0);
    check_value("cs_after", tb_if.cs_n, cs_after);
    @(posedge clk); #1;
    check_value("rv_pulse", tb_if.rx_valid, 0);
    if (poke) begin
      extra = 0;
      repeat (2 * LAT) begin
        @(posedge clk); #1;
        if (tb_if.rx_valid === 1'b1 || tb_if.busy === 1'b1) extra++;
      end
      check_value("no_queue", extra, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r_tx, r_rx;
    logic [1:0] r_sel;
    int         stray;
    tb_if.start   = 1'b0;
    tb_if.tx_data = '0;
    tb_if.cs_sel  = '0;
    tb_if.cpol    = 1'b0;
    tb_if.cpha    = 1'b0;
    tb_if.cs_hold = 1'b0;
    tb_if.miso    = 1'b0;
`ifdef SPI_LOOPBACK_EN
    tb_if.loopback = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_sclk", tb_if.sclk, 0);
    check_value("rst_mosi", tb_if.mosi, 0);
    check_value("rst_cs_n", tb_if.cs_n, 4'hF);
    check_value("rst_busy", tb_if.busy, 0);
    check_value("rst_rv", tb_if.rx_valid, 0);
    check_value("rst_rx", tb_if.rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    do_xfer(8'hA5, 8'h3C, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    do_xfer(8'hA5, 8'h3C, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    do_xfer(8'hA5, 8'h3C, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    do_xfer(8'h96, 8'h69, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    do_xfer(8'hC3, 8'h81, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    do_xfer(8'h3E, 8'h7E, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

    repeat (12) begin
      r_tx  = 8'($urandom());
      r_rx  = 8'($urandom());
      r_sel = 2'($urandom_range(0, 3));
      do_xfer(r_tx, r_rx, 1'($urandom()), 1'($urandom()), r_sel, 1'($urandom()), 1'b0, 1'b0);
    end

    // Abort a transfer mid-XFER with SCLK high and MOSI high.
    @(negedge clk);
    tb_if.tx_data = 8'hFF;
    tb_if.cpol    = 1'b1;
    tb_if.cpha    = 1'b0;
    tb_if.cs_sel  = 2'd1;
    tb_if.cs_hold = 1'b1;
    tb_if.start   = 1'b1;
    @(posedge clk); #1;
    tb_if.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_value("abort_sclk", tb_if.sclk, 0);
    check_value("abort_mosi", tb_if.mosi, 0);
    check_value("abort_cs_n", tb_if.cs_n, 4'hF);
    check_value("abort_busy", tb_if.busy, 0);
    check_value("abort_rx", tb_if.rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      if (tb_if.rx_valid === 1'b1) stray++;
    end
    check_value("abort_no_rv", stray, 0);
    do_xfer(8'h11, 8'hEE, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);

`ifdef SPI_LOOPBACK_EN
    do_xfer(8'h5A, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    repeat (4) begin
      r_tx = 8'($urandom());
      do_xfer(r_tx, 8'h00, 1'($urandom()), 1'($urandom()), 2'd1, 1'b0, 1'b0, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
